// File: rtl/icap_cmd_seq_if.sv
// Bundle between the ICAP command sequencer, its command client and the ICAPE2 primitive.
// Also carries the sequencer's state code so checkers can bind without hierarchical paths.
interface icap_cmd_seq_if;
    // Handshake: a command is taken on a rising edge where START=1 and READY=1.
    // START at any other time is dropped, not queued. DONE pulses for one cycle
    // when the ICAP sequence has finished; RDATA is valid from that cycle on.
    logic        START;
    logic        WRITE;
    logic [4:0]  ADDR;
    logic [31:0] WDATA;
    logic        READY;
    logic        DONE;
    logic [31:0] RDATA;
    logic        ICAP_CSIB;
    logic        ICAP_RDWRB;
    logic [31:0] ICAP_I;
    logic [31:0] ICAP_O;
    logic [2:0]  dbg_state;

    modport slave (
        input  START, WRITE, ADDR, WDATA, ICAP_O,
        output READY, DONE, RDATA, ICAP_CSIB, ICAP_RDWRB, ICAP_I, dbg_state
    );

    modport master (
        output START, WRITE, ADDR, WDATA, ICAP_O,
        input  READY, DONE, RDATA, ICAP_CSIB, ICAP_RDWRB, ICAP_I, dbg_state
    );
endinterface

// File: rtl/icap_cmd_seq.sv
// ICAPE2 single-register read/write sequencer: sync, type-1 access, desync.
// Optional macro ICAP_SEQ_BITSWAP_EN bit-reverses each byte on ICAP_I and ICAP_O.
module icap_cmd_seq #(
    parameter int INIT_CYCLES = 1024,
    parameter int READ_LAT    = 3
) (
    input  logic            CLK,
    input  logic            RSTB,
    icap_cmd_seq_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_SEQ     = 3'd2,
        ST_RD_TURN = 3'd3,
        ST_RD_WAIT = 3'd4,
        ST_RD_BACK = 3'd5,
        ST_DESYNC  = 3'd6
    } state_t;

    localparam int            IW        = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);
    localparam logic [3:0]    RD_LAST   = 4'(READ_LAT - 1);

    // ICAPE2 expects bit 0 of each byte on the pin that the bitstream calls bit 7.
    function automatic logic [31:0] byte_rev(input logic [31:0] w);
        logic [31:0] r;
`ifdef ICAP_SEQ_BITSWAP_EN
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 8; i++) begin
                r[8*b + i] = w[8*b + 7 - i];
            end
        end
`else
        r = w;
`endif
        return r;
    endfunction

    state_t        state_q, state_d;
    logic [IW-1:0] init_cnt_q, init_cnt_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          wr_q, wr_d;
    logic [4:0]    addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          done_q, done_d;

    logic          csib;
    logic          rdwrb;
    logic [31:0]   word;
    logic [31:0]   header;

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        done_d     = 1'b0;

        case (state_q)
            ST_INIT: begin
                if (init_cnt_q == INIT_LAST) begin
                    init_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (bus.START) begin
                    wr_d    = bus.WRITE;
                    addr_d  = bus.ADDR;
                    wdata_d = bus.WDATA;
                    cnt_d   = '0;
                    state_d = ST_SEQ;
                end
            end
            ST_SEQ: begin
                if (cnt_q == 4'd5) begin
                    cnt_d   = '0;
                    state_d = wr_q ? ST_DESYNC : ST_RD_TURN;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_RD_TURN: begin
                if (cnt_q == 4'd1) begin
                    cnt_d   = '0;
                    state_d = ST_RD_WAIT;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_RD_WAIT: begin
                if (cnt_q == RD_LAST) begin
                    cnt_d   = '0;
                    rdata_d = byte_rev(bus.ICAP_O);
                    state_d = ST_RD_BACK;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_RD_BACK: begin
                if (cnt_q == 4'd1) begin
                    cnt_d   = '0;
                    state_d = ST_DESYNC;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_DESYNC: begin
                if (cnt_q == 4'd3) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_INIT;
            end
        endcase
    end

    assign header = (wr_q ? 32'h3000_0001 : 32'h2800_0001) | (32'(addr_q) << 13);

    // RDWRB only moves while CSIB=1: the turn/back states step it in their second cycle.
    always_comb begin
        csib  = 1'b1;
        rdwrb = 1'b0;
        word  = 32'h0000_0000;
        case (state_q)
            ST_SEQ: begin
                csib = 1'b0;
                case (cnt_q)
                    4'd0:    word = 32'hFFFF_FFFF;
                    4'd1:    word = 32'hAA99_5566;
                    4'd3:    word = header;
                    4'd4:    word = wr_q ? wdata_q : 32'h2000_0000;
                    default: word = 32'h2000_0000;
                endcase
            end
            ST_RD_TURN: rdwrb = cnt_q[0];
            ST_RD_WAIT: begin
                csib  = 1'b0;
                rdwrb = 1'b1;
            end
            ST_RD_BACK: rdwrb = ~cnt_q[0];
            ST_DESYNC: begin
                csib = 1'b0;
                case (cnt_q)
                    4'd0:    word = 32'h3000_8001;
                    4'd1:    word = 32'h0000_000D;
                    default: word = 32'h2000_0000;
                endcase
            end
            default: begin
                csib  = 1'b1;
                rdwrb = 1'b0;
                word  = 32'h0000_0000;
            end
        endcase
    end

    assign bus.ICAP_CSIB  = csib;
    assign bus.ICAP_RDWRB = rdwrb;
    assign bus.ICAP_I     = byte_rev(word);
    assign bus.READY      = (state_q == ST_IDLE);
    assign bus.DONE       = done_q;
    assign bus.RDATA      = rdata_q;
    assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_icap_cmd_seq.sv
// Directed bench for icap_cmd_seq: reset/INIT timing, write, read, busy START, mid-read reset.
// Define ICAP_SEQ_BITSWAP_EN for both DUT and bench to exercise the byte bit-reversal.
module tb_icap_cmd_seq;

    localparam int INIT_CYCLES = 1024;
    localparam int READ_LAT    = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    icap_cmd_seq_if bus();

    icap_cmd_seq #(
        .INIT_CYCLES(INIT_CYCLES),
        .READ_LAT   (READ_LAT)
    ) dut (
        .CLK (clk),
        .RSTB(rst_n),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    endtask

    function automatic logic [31:0] pin(input logic [31:0] w);
        logic [31:0] r;
        r = w;
`ifdef ICAP_SEQ_BITSWAP_EN
        for (int b = 0; b < 4; b++) begin
            logic [7:0] x;
            x = w[8*b +: 8];
            r[8*b +: 8] = {x[0], x[1], x[2], x[3], x[4], x[5], x[6], x[7]};
        end
`endif
        return r;
    endfunction

    // ICAPE2 pin value the model returns and the RDATA it must produce
`ifdef ICAP_SEQ_BITSWAP_EN
    localparam logic [31:0] RD_PIN  = 32'hC04E_4EC0;
    localparam logic [31:0] RD_EXP  = 32'h0372_7203;
`else
    localparam logic [31:0] RD_PIN  = 32'h0372_7093;
    localparam logic [31:0] RD_EXP  = 32'h0372_7093;
`endif

    logic [31:0] got_q[$];
    int          proto_err = 0;
    int          done_cnt  = 0;
    int          wait_cnt  = 0;
    int          last_wait = 0;
    logic        prev_rdwrb = 1'b0;

    // ICAPE2 model and pin monitor; O shows data only on the READ_LAT-th RD_WAIT cycle
    always @(negedge clk) begin
        if (!bus.ICAP_CSIB && (bus.ICAP_RDWRB !== prev_rdwrb)) proto_err++;
        if (bus.ICAP_CSIB && (bus.ICAP_I !== 32'h0)) proto_err++;
        if (!bus.ICAP_CSIB && !bus.ICAP_RDWRB) got_q.push_back(bus.ICAP_I);
        if (!bus.ICAP_CSIB && bus.ICAP_RDWRB) begin
            wait_cnt++;
        end else begin
            if (wait_cnt != 0) last_wait = wait_cnt;
            wait_cnt = 0;
        end
        bus.ICAP_O = (!bus.ICAP_CSIB && bus.ICAP_RDWRB && wait_cnt == READ_LAT) ? RD_PIN : 32'h5A5A_A5A5;
        if (bus.DONE === 1'b1) done_cnt++;
        prev_rdwrb = bus.ICAP_RDWRB;
    end

    task automatic wait_init(input string tag);
        int lat;
        int csib_bad;
        lat = 0;
        csib_bad = 0;
        rst_n = 1'b1;
        while (bus.READY !== 1'b1 && lat < 2000) begin
            @(negedge clk);
            lat++;
            if (bus.ICAP_CSIB !== 1'b1) csib_bad++;
        end
        check({tag, "_init_len"}, 32'(lat), 32'(INIT_CYCLES));
        check({tag, "_init_csib"}, 32'(csib_bad), 32'd0);
        check({tag, "_idle_state"}, 32'(bus.dbg_state), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_csib", 32'(bus.ICAP_CSIB), 32'd1);
        check("rst_rdwrb", 32'(bus.ICAP_RDWRB), 32'd0);
        check("rst_i", bus.ICAP_I, 32'h0);
        check("rst_ready", 32'(bus.READY), 32'd0);
        check("rst_done", 32'(bus.DONE), 32'd0);
        check("rst_rdata", bus.RDATA, 32'h0);
        check("rst_state", 32'(bus.dbg_state), 32'd0);
        wait_init("rst");
    endtask

    // Issues one command from a negedge with READY=1; returns cycles from accept to DONE.
    task automatic run_cmd(input logic wr, input logic [4:0] addr, input logic [31:0] wdata,
                           input logic hold, output int done_at, output int busy_ready);
        int cyc;
        cyc = 0;
        busy_ready = 0;
        bus.START = 1'b1;
        bus.WRITE = wr;
        bus.ADDR  = addr;
        bus.WDATA = wdata;
        done_at   = -1;
        while (cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (!hold) bus.START = 1'b0;
            if (bus.DONE === 1'b1) begin
                done_at = cyc;
                break;
            end
            if (bus.READY !== 1'b0) busy_ready++;
        end
        bus.START = 1'b0;
        if (done_at < 0) check("done_timeout", 32'(cyc), 32'd0);
    endtask

    task automatic check_words(input string tag, input int base, input logic [31:0] exp [10]);
        check({tag, "_nwords"}, 32'(got_q.size() - base), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (base + i < got_q.size())
                check($sformatf("%s_w%0d", tag, i), got_q[base + i], pin(exp[i]));
        end
    endtask

    logic [31:0] wr_exp [10];
    logic [31:0] rd_exp [10];

    initial begin
        int base;
        int d0;
        int done_at;
        int busy_ready;
        int guard;

        bus.START = 1'b0;
        bus.WRITE = 1'b0;
        bus.ADDR  = '0;
        bus.WDATA = '0;
        wr_exp = '{32'hFFFF_FFFF, 32'hAA99_5566, 32'h2000_0000, 32'h3000_8001, 32'h0000_000D,
                   32'h2000_0000, 32'h3000_8001, 32'h0000_000D, 32'h2000_0000, 32'h2000_0000};
        rd_exp = '{32'hFFFF_FFFF, 32'hAA99_5566, 32'h2000_0000, 32'h2801_8001, 32'h2000_0000,
                   32'h2000_0000, 32'h3000_8001, 32'h0000_000D, 32'h2000_0000, 32'h2000_0000};

        @(negedge clk);
        do_reset();

        // plain write to register 04
        base = got_q.size();
        d0 = done_cnt;
        run_cmd(1'b1, 5'h04, 32'h0000_000D, 1'b0, done_at, busy_ready);
        check("wr_done_at", 32'(done_at), 32'd11);
        check("wr_ready_busy", 32'(busy_ready), 32'd0);
        check_words("wr", base, wr_exp);
`ifdef ICAP_SEQ_BITSWAP_EN
        check("swap_sync", got_q[base + 1], 32'h5599_AA66);
`endif
        @(negedge clk);
        check("wr_done_pulse", 32'(bus.DONE), 32'd0);
        check("wr_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("wr_rdata_kept", bus.RDATA, 32'h0);

        // START held through the whole write: one command only
        base = got_q.size();
        d0 = done_cnt;
        run_cmd(1'b1, 5'h04, 32'h0000_000D, 1'b1, done_at, busy_ready);
        check("busy_done_at", 32'(done_at), 32'd11);
        check("busy_ready_low", 32'(busy_ready), 32'd0);
        repeat (20) @(negedge clk);
        check_words("busy", base, wr_exp);
        check("busy_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("busy_ready_after", 32'(bus.READY), 32'd1);

        // read of register 0C
        base = got_q.size();
        d0 = done_cnt;
        run_cmd(1'b0, 5'h0C, 32'hDEAD_BEEF, 1'b0, done_at, busy_ready);
        check("rd_done_at", 32'(done_at), 32'd18);
        check("rd_ready_busy", 32'(busy_ready), 32'd0);
        check_words("rd", base, rd_exp);
        check("rd_wait_len", 32'(last_wait), 32'(READ_LAT));
        check("rd_rdata", bus.RDATA, RD_EXP);
        repeat (3) @(negedge clk);
        check("rd_done_cnt", 32'(done_cnt - d0), 32'd1);

        // a write must leave RDATA alone
        run_cmd(1'b1, 5'h1F, 32'h1234_5678, 1'b0, done_at, busy_ready);
        check("wr2_done_at", 32'(done_at), 32'd11);
        check("wr2_rdata_kept", bus.RDATA, RD_EXP);
        @(negedge clk);

        // reset asserted while waiting for read data
        d0 = done_cnt;
        bus.START = 1'b1;
        bus.WRITE = 1'b0;
        bus.ADDR  = 5'h0C;
        guard = 0;
        do begin
            @(negedge clk);
            bus.START = 1'b0;
            guard++;
        end while (!(bus.ICAP_CSIB === 1'b0 && bus.ICAP_RDWRB === 1'b1) && guard < 40);
        check("mid_reach_wait", 32'(guard < 40), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_csib", 32'(bus.ICAP_CSIB), 32'd1);
        check("mid_rdwrb", 32'(bus.ICAP_RDWRB), 32'd0);
        check("mid_ready", 32'(bus.READY), 32'd0);
        check("mid_rdata", bus.RDATA, 32'h0);
        repeat (4) @(negedge clk);
        wait_init("mid");
        check("mid_no_done", 32'(done_cnt - d0), 32'd0);
        check("mid_rdata_after", bus.RDATA, 32'h0);

        check("protocol", 32'(proto_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
